// File: rtl/sync_serial_tx_pkg.sv
// sync_serial_tx_pkg: FSM state type and sizing helpers shared by the serial transmitter.
package sync_serial_tx_pkg;

    typedef enum logic [1:0] {IDLE, PRE, DATA} state_e;

    // Width of a counter running 0..n-1, never narrower than one bit.
    function automatic int cnt_w(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

    function automatic int slots_per_word(input int data_w, input int lanes);
        return data_w / lanes;
    endfunction

endpackage

// File: rtl/sync_fifo_w.sv
// sync_fifo_w: single-clock word FIFO with registered occupancy; pushes while full are dropped.
module sync_fifo_w #(
    parameter int DATA_W = 16,
    parameter int DEPTH  = 4
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       i_push,
    input  logic [DATA_W-1:0]          i_wdata,
    input  logic                       i_pop,
    output logic [DATA_W-1:0]          o_rdata,
    output logic [$clog2(DEPTH+1)-1:0] o_level,
    output logic                       o_full,
    output logic                       o_empty
);
    localparam int AW = $clog2(DEPTH);
    localparam int LW = $clog2(DEPTH + 1);

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [AW-1:0]     wp_q, wp_d, rp_q, rp_d;
    logic [LW-1:0]     level_q, level_d;
    logic              wr;

    always_comb begin
        wr      = i_push && !o_full;
        wp_d    = wr ? wp_q + 1'b1 : wp_q;
        rp_d    = i_pop ? rp_q + 1'b1 : rp_q;
        level_d = level_q + LW'(wr) - LW'(i_pop);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wp_q    <= '0;
            rp_q    <= '0;
            level_q <= '0;
        end else begin
            wp_q    <= wp_d;
            rp_q    <= rp_d;
            level_q <= level_d;
        end
    end

    always_ff @(posedge clk) begin
        if (wr) mem_q[wp_q] <= i_wdata;
    end

    assign o_rdata = mem_q[rp_q];
    assign o_level = level_q;
    assign o_full  = level_q == LW'(DEPTH);
    assign o_empty = level_q == '0;

endmodule

// File: rtl/sync_serial_tx.sv
// sync_serial_tx: framed multi-lane serial transmitter with gated bit clock, frame sync and input FIFO.
module sync_serial_tx
    import sync_serial_tx_pkg::*;
#(
    parameter int DATA_W     = 16,
    parameter int LANES      = 1,
    parameter int CLK_DIV    = 1,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic [DATA_W-1:0]               i_tx_data,
    input  logic                            i_tx_vld,
    output logic                            o_tx_rdy,
    output logic [$clog2(FIFO_DEPTH+1)-1:0] o_level,
    output logic                            o_busy,
    output logic                            o_fs,
    output logic [LANES-1:0]                o_d,
    output logic                            o_clk
);
    localparam int BPW  = slots_per_word(DATA_W, LANES);
    localparam int SLOT = 2 * CLK_DIV;
    localparam int CW   = cnt_w(SLOT);
    localparam int IW   = cnt_w(BPW);
    localparam int LW   = $clog2(FIFO_DEPTH + 1);

    state_e            state_q, state_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [IW-1:0]     idx_q, idx_d;
    logic [DATA_W-1:0] shift_q, shift_d, nxt_q, nxt_d;
    logic              more_q, more_d, fetch_q, fetch_d, fs_q, fs_d;
    logic [LANES-1:0]  d_q, d_d;
    logic [DATA_W-1:0] head;
    logic [LW-1:0]     level;
    logic              full, empty, pop, slot_end, dec;

    sync_fifo_w #(.DATA_W(DATA_W), .DEPTH(FIFO_DEPTH)) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_push  (i_tx_vld),
        .i_wdata (i_tx_data),
        .i_pop   (pop),
        .o_rdata (head),
        .o_level (level),
        .o_full  (full),
        .o_empty (empty)
    );

    always_comb begin
        slot_end = (state_q != IDLE) && (cnt_q == CW'(SLOT - 1));
        cnt_d    = (slot_end || state_q == IDLE) ? '0 : cnt_q + 1'b1;
        state_d  = state_q;
        idx_d    = idx_q;
        shift_d  = shift_q;
        nxt_d    = fetch_q ? head : nxt_q;
        more_d   = more_q;
        fetch_d  = 1'b0;
        pop      = fetch_q;
        fs_d     = fs_q;
        d_d      = d_q;
        dec      = 1'b0;
        case (state_q)
            IDLE: if (!empty) begin
                state_d = PRE;
                fs_d    = 1'b1;
            end
            PRE: if (slot_end) begin
                // One-slot words must decide on the follower now; it is fetched a cycle later.
                state_d = DATA;
                pop     = 1'b1;
                shift_d = head << LANES;
                d_d     = head[DATA_W-1 -: LANES];
                idx_d   = '0;
                more_d  = (BPW == 1) && (level > LW'(1));
                fetch_d = more_d;
                fs_d    = more_d;
            end
            DATA: if (slot_end) begin
                fs_d   = 1'b0;
                more_d = 1'b0;
                if (idx_q != IW'(BPW - 1)) begin
                    shift_d = shift_q << LANES;
                    d_d     = shift_q[DATA_W-1 -: LANES];
                    idx_d   = idx_q + 1'b1;
                    dec     = idx_q == IW'(BPW - 2);
                end else if (more_q) begin
                    shift_d = nxt_q << LANES;
                    d_d     = nxt_q[DATA_W-1 -: LANES];
                    idx_d   = '0;
                    dec     = BPW == 1;
                end else begin
                    state_d = IDLE;
                    d_d     = '0;
                end
            end
            default: state_d = IDLE;
        endcase
        if (dec) begin
            fs_d   = !empty;
            more_d = !empty;
            pop    = !empty;
            nxt_d  = head;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            idx_q   <= '0;
            shift_q <= '0;
            nxt_q   <= '0;
            more_q  <= 1'b0;
            fetch_q <= 1'b0;
            fs_q    <= 1'b0;
            d_q     <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            shift_q <= shift_d;
            nxt_q   <= nxt_d;
            more_q  <= more_d;
            fetch_q <= fetch_d;
            fs_q    <= fs_d;
            d_q     <= d_d;
        end
    end

    assign o_tx_rdy = !full;
    assign o_level  = level;
    assign o_busy   = state_q != IDLE;
    assign o_fs     = fs_q;
    assign o_d      = d_q;
    assign o_clk    = o_busy && (cnt_q >= CW'(CLK_DIV));

endmodule

// File: tb/tb_sync_serial_tx.sv
// tb_sync_serial_tx: directed bench for a 16x1 clk/2 transmitter and a 16x4 clk/6 transmitter.
module tb_sync_serial_tx;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic [15:0] a_data, b_data;
    logic        a_vld, b_vld, a_rdy, b_rdy, a_busy, b_busy, a_fs, b_fs, a_clk, b_clk;
    logic [2:0]  a_level, b_level;
    logic [0:0]  a_d;
    logic [3:0]  b_d;

    sync_serial_tx #(.DATA_W(16), .LANES(1), .CLK_DIV(1), .FIFO_DEPTH(4)) u_a (
        .clk(clk), .rst_n(rst_n), .i_tx_data(a_data), .i_tx_vld(a_vld), .o_tx_rdy(a_rdy),
        .o_level(a_level), .o_busy(a_busy), .o_fs(a_fs), .o_d(a_d), .o_clk(a_clk)
    );

    sync_serial_tx #(.DATA_W(16), .LANES(4), .CLK_DIV(3), .FIFO_DEPTH(4)) u_b (
        .clk(clk), .rst_n(rst_n), .i_tx_data(b_data), .i_tx_vld(b_vld), .o_tx_rdy(b_rdy),
        .o_level(b_level), .o_busy(b_busy), .o_fs(b_fs), .o_d(b_d), .o_clk(b_clk)
    );

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Receiver model: capture {fs, d} at every o_clk rising edge.
    logic       a_prev = 1'b0;
    int         a_busy_n = 0;
    logic [1:0] a_line[$];
    always @(negedge clk) begin
        if (a_clk && !a_prev) a_line.push_back({a_fs, a_d});
        a_prev <= a_clk;
        if (a_busy) a_busy_n <= a_busy_n + 1;
    end

    logic       b_prev = 1'b0, b_pbusy = 1'b0;
    logic [4:0] b_pval = '0, b_rise_val = '0;
    int         b_busy_n = 0, b_hi_n = 0, b_bad = 0, b_run = 0;
    logic [4:0] b_line[$];
    always @(negedge clk) begin
        if (b_clk && !b_prev) begin
            b_line.push_back({b_fs, b_d});
            b_rise_val <= {b_fs, b_d};
        end
        if (!b_busy) b_run <= 0;
        else if (b_clk != b_prev) begin
            if (b_run != 3) b_bad <= b_bad + 1;
            b_run <= 1;
        end else b_run <= b_run + 1;
        if ((b_clk && b_prev && {b_fs, b_d} != b_rise_val) ||
            ({b_fs, b_d} != b_pval && !(!b_clk && (b_prev || !b_pbusy))))
            b_bad <= b_bad + 1;
        b_pval  <= {b_fs, b_d};
        b_prev  <= b_clk;
        b_pbusy <= b_busy;
        if (b_busy) b_busy_n <= b_busy_n + 1;
        if (b_clk) b_hi_n <= b_hi_n + 1;
    end

    function automatic logic [63:0] a_fs_bits(input int s, input int n);
        logic [63:0] r = '0;
        for (int i = 0; i < n; i++) r = {r[62:0], a_line[s+i][1]};
        return r;
    endfunction

    function automatic logic [63:0] a_d_bits(input int s, input int n);
        logic [63:0] r = '0;
        for (int i = 0; i < n; i++) r = {r[62:0], a_line[s+i][0]};
        return r;
    endfunction

    task automatic push_a(input logic [15:0] w);
        @(negedge clk);
        a_data = w;
        a_vld  = 1'b1;
        @(negedge clk);
        a_vld  = 1'b0;
    endtask

    task automatic wait_idle(input string tag);
        int n = 0;
        @(negedge clk);
        while ((a_busy || b_busy || a_level != 0 || b_level != 0) && n < 3000) begin
            @(negedge clk);
            n++;
        end
        #1;
        check({tag, "_done"}, 64'(n < 3000), 1);
    endtask

    initial begin
        int s, b0, h0, bad0, n;
        logic [63:0] r;
        int exp_lvl[8] = '{1, 2, 3, 3, 4, 4, 4, 4};
        a_vld = 1'b0; a_data = '0; b_vld = 1'b0; b_data = '0;
        repeat (3) @(negedge clk);
        check("rst_rdy", a_rdy, 1);
        check("rst_level", a_level, 0);
        check("rst_busy", a_busy, 0);
        check("rst_line", {a_clk, a_fs, a_d}, 0);
        rst_n = 1'b1;
        @(negedge clk);

        // single word, 1 lane, clk/2
        s = a_line.size(); b0 = a_busy_n;
        push_a(16'hA5C3);
        wait_idle("t1");
        check("t1_slots", 64'(a_line.size() - s), 17);
        check("t1_fs", a_fs_bits(s, 17), 64'h1_0000);
        check("t1_d", a_d_bits(s, 17), 64'hA5C3);
        check("t1_busy", 64'(a_busy_n - b0), 34);

        // back-to-back words form one seamless burst
        s = a_line.size(); b0 = a_busy_n;
        @(negedge clk); a_data = 16'h1234; a_vld = 1'b1;
        @(negedge clk); a_data = 16'h5678;
        @(negedge clk); a_vld = 1'b0;
        wait_idle("t2");
        check("t2_slots", 64'(a_line.size() - s), 33);
        check("t2_fs", a_fs_bits(s, 33), 64'h1_0001_0000);
        check("t2_d", a_d_bits(s, 33), 64'h1234_5678);
        check("t2_busy", 64'(a_busy_n - b0), 66);

        // 4 lanes, slot of 6 clk
        s = b_line.size(); b0 = b_busy_n; h0 = b_hi_n; bad0 = b_bad;
        @(negedge clk); b_data = 16'hF0A5; b_vld = 1'b1;
        @(negedge clk); b_vld = 1'b0;
        wait_idle("t3");
        r = '0;
        for (int i = 0; i < 5; i++) r = {r[58:0], b_line[s+i]};
        check("t3_slots", 64'(b_line.size() - s), 5);
        check("t3_line", r, {44'h0, 5'h10, 5'h0F, 5'h00, 5'h0A, 5'h05});
        check("t4_busy", 64'(b_busy_n - b0), 30);
        check("t4_high", 64'(b_hi_n - h0), 15);
        check("t4_shape", 64'(b_bad - bad0), 0);

        // FIFO fill: 8 offered cycles, 5 accepted
        s = a_line.size();
        @(negedge clk); a_vld = 1'b1;
        for (int i = 0; i < 8; i++) begin
            a_data = 16'hC000 + 16'(i);
            @(negedge clk);
            check("t5_level", a_level, 64'(exp_lvl[i]));
            check("t5_rdy", a_rdy, 64'(i < 4));
        end
        a_vld = 1'b0;
        wait_idle("t5");
        check("t5_slots", 64'(a_line.size() - s), 81);
        for (int k = 0; k < 5; k++) check("t5_word", a_d_bits(s + 1 + 16*k, 16), 64'(16'hC000 + 16'(k)));
        n = 0;
        for (int i = 0; i < 81; i++) n += int'(a_line[s+i][1]);
        check("t5_fs_count", 64'(n), 5);

        // asynchronous reset during slot 7
        s = a_line.size();
        push_a(16'hA5C3);
        push_a(16'h1111);
        n = 0;
        while (a_line.size() < s + 8 && n < 200) begin
            @(negedge clk); #1;
            n++;
        end
        check("t6_reach", 64'(n < 200), 1);
        @(negedge clk);
        @(negedge clk); #1;
        check("t6_pre_clk", a_clk, 1);
        check("t6_pre_d", a_d, 1);
        check("t6_pre_level", a_level, 1);
        rst_n = 1'b0;
        #1;
        check("t6_rst_line", {a_clk, a_fs, a_d}, 0);
        check("t6_rst_level", a_level, 0);
        check("t6_rst_rdy", a_rdy, 1);
        check("t6_rst_busy", a_busy, 0);
        @(negedge clk); rst_n = 1'b1;
        repeat (40) @(negedge clk);
        #1;
        check("t6_quiet", 64'(a_line.size() - s), 9);
        check("t6_idle", a_busy, 0);

        // word arriving one cycle after the last-slot decision starts a new burst
        s = a_line.size(); b0 = a_busy_n;
        push_a(16'h8001);
        repeat (33) @(negedge clk);
        a_data = 16'h7FFE; a_vld = 1'b1;
        @(negedge clk); a_vld = 1'b0;
        wait_idle("t7");
        check("t7_slots", 64'(a_line.size() - s), 34);
        check("t7_fs", a_fs_bits(s, 34), 64'h2_0001_0000);
        check("t7_d", a_d_bits(s, 34), 64'h1_0002_7FFE);
        check("t7_busy", 64'(a_busy_n - b0), 68);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/sync_serial_tx.md
Name: sync_serial_tx

Overview:
Parametrised synchronous serial transmitter: framed words out on a gated bit clock, frame-sync and 1..N parallel data lanes.
Next generation of the single-lane 16-bit frame/data/clock transmitter in the rcvr path.
Adds configurable word width, lane count, bit-clock divider and an input FIFO.
Bursts are seamless while the FIFO holds data; a one-slot preamble precedes each burst.

Parameters:
DATA_W, 16, word width in bits; must be a multiple of LANES
LANES, 1, number of parallel serial data lanes
CLK_DIV, 1, half-period of o_clk in clk cycles (slot = 2*CLK_DIV clk); >=1
FIFO_DEPTH, 4, input FIFO depth in words; power of 2, >=2

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous, active-low reset
i_tx_data  in  DATA_W  word to transmit
i_tx_vld  in  1  word valid
o_tx_rdy  out  1  FIFO can accept; transfer on i_tx_vld & o_tx_rdy at posedge clk
o_level  out  $clog2(FIFO_DEPTH+1)  FIFO occupancy
o_busy  out  1  FSM not IDLE
o_fs  out  1  frame sync: next slot starts a new word
o_d  out  LANES  serial data; o_d[LANES-1] carries the most significant bit of each slot
o_clk  out  1  bit clock; idle low

Behaviour:
- Reset (async): FIFO empty, o_level=0, o_tx_rdy=1, o_busy=0, o_fs=0, o_d=0, o_clk=0, FSM=IDLE; any word in flight is discarded.
- Constants: BPW = DATA_W/LANES slots per word. Slot = 2*CLK_DIV clk cycles: o_clk low for the first CLK_DIV cycles, high for the second CLK_DIV.
- o_fs and o_d change only at slot start (clk edge where o_clk falls or starts); receiver samples on o_clk rising edge.
- FIFO:
  - o_tx_rdy = (level < FIFO_DEPTH).
  - Push and pop in the same cycle leaves the level unchanged.
  - Push when full is ignored; pop when empty never occurs.
  - o_level is registered.
- FSM states:
  - IDLE: o_clk=0, o_fs=0, o_d=0. If FIFO non-empty at a clk edge, enter PRE.
    - Latency: word pushed at edge T into an empty FIFO → PRE starts at edge T+1; first o_clk rise at T+1+CLK_DIV.
  - PRE: one slot, o_fs=1, o_d=0. At PRE end: pop FIFO head into shifter, enter DATA with slot index 0, o_fs=0.
  - DATA:
    - o_d = shifter[DATA_W-1 -: LANES]; shifter shifts left by LANES each slot, zero-fill.
    - At start of slot BPW-1, sample FIFO non-empty:
      - If non-empty: o_fs=1 for that slot and pop head into next-word register. At slot end, load shifter from next-word register, slot index 0, stay in DATA; no gap slots.
      - If empty: o_fs=0. At slot end, go to IDLE; o_clk stays low, o_d=0.
    - A word pushed after the slot BPW-1 decision is not appended; it starts a new burst with PRE.
- BPW=1: every DATA slot is a last slot. o_fs follows the same rule, set at the start of that slot.
- o_busy=1 in PRE and DATA.
- CLK_DIV=1, LANES=1, DATA_W=16 produces an o_clk at clk/2 with a 1-slot preamble, MSB first.
- Reset asserted mid-slot: all outputs drop asynchronously to reset values. After release, FSM restarts from IDLE.

Decomposition:
- Package sync_serial_tx_pkg: FSM state enum (IDLE, PRE, DATA); localparam helpers for BPW and counter widths.
- Sub-module sync_fifo_w: single-clock FIFO, DATA_W x FIFO_DEPTH, with push/pop/level/full/empty.
- Slot timing counter and shifter live in the top module.

Test Plan:
1. DATA_W=16, LANES=1, CLK_DIV=1; push 0xA5C3 once → 1 PRE slot (fs=1, d=0), then 16 slots 1010010111000011, fs=0 throughout, 17 o_clk pulses, o_busy 34 cycles, return to IDLE.
2. Same config; push 0x1234 then 0x5678 back-to-back → single PRE, fs=1 only during slot 15 of the first word, second word immediately follows, 33 slots total, no gap.
3. DATA_W=16, LANES=4; push 0xF0A5 → PRE then 4 slots o_d = 0xF, 0x0, 0xA, 0x5.
4. CLK_DIV=3 → o_clk low 3, high 3 cycles; o_d/o_fs stable across each rising edge and change only at slot start.
5. FIFO_DEPTH=4; hold i_tx_vld for 8 consecutive cycles from IDLE → o_tx_rdy drops when o_level=4; exactly the accepted words appear on the line, in order, with none lost or duplicated.
6. Reset and late arrival:
   - rst_n low during slot 7 of a word → o_clk/o_fs/o_d=0 immediately; o_level=0, o_tx_rdy=1; no output after release until a new push.
   - Separately, a word pushed 1 cycle after the last-slot decision → fs stays 0, line returns to IDLE, new PRE follows.
